// File: rtl/pe_result_reader.sv
// PE result reader: buffers 16-bit PE results in a small FIFO and serializes each word
// onto an 8-bit pad bus, low byte first, with valid/ready flow control on both sides.
module pe_result_reader #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              res_valid,
   input  logic [DATA_W-1:0] res_data,
   output logic              res_ready,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [7:0]        out_byte,
   output logic              out_last,
   output logic [7:0]        bus_oe,
   output logic [2:0]        fifo_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

   state_e            state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [2:0]        count_q, count_d;
   logic [DATA_W-1:0] hold_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              push, pop;

   // Ready depends only on the registered count, never on the output side.
   assign res_ready  = (count_q < 3'(DEPTH));
   assign push       = res_valid & res_ready;
   assign fifo_count = count_q;

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q != 3'd0) begin
               pop     = 1'b1;
               state_d = StLo;
            end
         end
         StLo: begin
            if (out_ready) state_d = StHi;
         end
         StHi: begin
            // Refill straight from the FIFO so consecutive words have no gap.
            if (out_ready) begin
               if (count_q != 3'd0) begin
                  pop     = 1'b1;
                  state_d = StLo;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 3'd1;
      end else if (!push && pop) begin
         count_d = count_q - 3'd1;
      end
   end

   always_comb begin
      out_valid = (state_q != StIdle);
      out_byte  = 8'h00;
      out_last  = 1'b0;
      if (state_q == StLo) begin
         out_byte = hold_q[7:0];
      end else if (state_q == StHi) begin
         out_byte = hold_q[15:8];
         out_last = 1'b1;
      end
      bus_oe = out_valid ? 8'hFF : 8'h00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= 3'd0;
         hold_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            hold_q   <= mem[rd_ptr_q];
         end
      end
   end

   // Storage is data only; it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= res_data;
      end
   end

endmodule

// File: tb/tb_pe_result_reader.sv
// Self-checking bench for pe_result_reader: directed vector table, multi-cycle corner
// sequences, and a random stream checked by a queue-based byte-stream model.
module tb_pe_result_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        res_valid = 1'b0;
   logic [15:0] res_data = 16'h0000;
   logic        res_ready;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [7:0]  out_byte;
   logic        out_last;
   logic [7:0]  bus_oe;
   logic [2:0]  fifo_count;

   pe_result_reader #(.DATA_W(16), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_ready  (res_ready),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_byte   (out_byte),
      .out_last   (out_last),
      .bus_oe     (bus_oe),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: words accepted but not yet fully emitted, oldest first.
   logic [15:0] model_q[$];
   bit          byte_idx = 1'b0;
   int          words_done = 0;
   bit          mon_en = 1'b0;

   typedef struct {
      logic [15:0] data;
      logic [7:0]  lo;
      logic [7:0]  hi;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      out_ready = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (model_q.size() == 0 && !out_valid) break;
         tick();
      end
      check("drain_done", {31'd0, (model_q.size() == 0) && !out_valid}, 32'd1);
   endtask

   // Continuous stream monitor, sampling on the falling edge.
   always @(negedge clk) begin
      int          exp_cnt;
      logic [15:0] w;
      if (mon_en) begin
         exp_cnt = model_q.size() - (out_valid ? 1 : 0);
         check("fifo_count", {29'd0, fifo_count}, exp_cnt);
         check("res_ready", {31'd0, res_ready}, {31'd0, exp_cnt < 4});
         check("bus_oe", {24'd0, bus_oe}, out_valid ? 32'hFF : 32'h00);
         if (!out_valid) begin
            check("idle_out", {23'd0, out_last, out_byte}, 32'd0);
         end else if (model_q.size() == 0) begin
            check("stale_valid", {31'd0, out_valid}, 32'd0);
         end else begin
            w = model_q[0];
            check("out_byte", {24'd0, out_byte}, byte_idx ? {24'd0, w[15:8]} : {24'd0, w[7:0]});
            check("out_last", {31'd0, out_last}, {31'd0, byte_idx});
            if (out_ready) begin
               if (byte_idx) begin
                  void'(model_q.pop_front());
                  words_done++;
                  byte_idx = 1'b0;
               end else begin
                  byte_idx = 1'b1;
               end
            end
         end
         if (res_valid && res_ready) model_q.push_back(res_data);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          acc, idx, start_done, sent, cyc;
      bit          accepted;
      logic [15:0] cur;
      logic [15:0] bp_words[6];
      logic [7:0]  b2b[4];

      vecs[0] = '{16'hBEEF, 8'hEF, 8'hBE};
      vecs[1] = '{16'h0000, 8'h00, 8'h00};
      vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF};
      vecs[3] = '{16'h1234, 8'h34, 8'h12};
      vecs[4] = '{16'hA55A, 8'h5A, 8'hA5};

      // Reset takes effect before any clock edge.
      #1 rst = 1'b1;
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_byte", {24'd0, out_byte}, 32'd0);
      check("rst_out_last", {31'd0, out_last}, 32'd0);
      check("rst_bus_oe", {24'd0, bus_oe}, 32'd0);
      check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
      check("rst_res_ready", {31'd0, res_ready}, 32'd1);
      tick();
      rst = 1'b0;
      mon_en = 1'b1;
      tick();

      // Single words from the table, with latency and pad-enable timing.
      for (int i = 0; i < 5; i++) begin
         out_ready = 1'b1;
         res_data  = vecs[i].data;
         res_valid = 1'b1;
         check("vec_ready", {31'd0, res_ready}, 32'd1);
         tick();
         res_valid = 1'b0;
         check("vec_latency_n", {31'd0, out_valid}, 32'd0);
         tick();
         check("vec_lo_valid", {31'd0, out_valid}, 32'd1);
         check("vec_lo_byte", {24'd0, out_byte}, {24'd0, vecs[i].lo});
         check("vec_lo_last", {31'd0, out_last}, 32'd0);
         check("vec_lo_oe", {24'd0, bus_oe}, 32'hFF);
         tick();
         check("vec_hi_byte", {24'd0, out_byte}, {24'd0, vecs[i].hi});
         check("vec_hi_last", {31'd0, out_last}, 32'd1);
         check("vec_hi_oe", {24'd0, bus_oe}, 32'hFF);
         tick();
         check("vec_end_valid", {31'd0, out_valid}, 32'd0);
         check("vec_end_oe", {24'd0, bus_oe}, 32'h00);
      end

      // Back-to-back words with no bubble.
      b2b[0] = 8'h34; b2b[1] = 8'h12; b2b[2] = 8'h78; b2b[3] = 8'h56;
      out_ready = 1'b1;
      res_valid = 1'b1;
      res_data  = 16'h1234;
      tick();
      res_data = 16'h5678;
      tick();
      res_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("b2b_valid", {31'd0, out_valid}, 32'd1);
         check("b2b_byte", {24'd0, out_byte}, {24'd0, b2b[i]});
         tick();
      end
      check("b2b_end", {31'd0, out_valid}, 32'd0);

      // Backpressure until full: DEPTH+1 words buffered in total.
      for (int i = 0; i < 6; i++) bp_words[i] = 16'h1100 + 16'(i * 16'h0101);
      out_ready = 1'b0;
      acc = 0;
      idx = 0;
      for (int i = 0; i < 6; i++) begin
         res_valid = 1'b1;
         res_data  = bp_words[idx];
         if (res_ready) begin
            acc++;
            idx++;
         end
         tick();
      end
      res_valid = 1'b0;
      check("bp_accepted", acc, 32'd5);
      check("bp_fifo_count", {29'd0, fifo_count}, 32'd4);
      check("bp_res_ready", {31'd0, res_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("bp_hold_byte", {24'd0, out_byte}, {24'd0, bp_words[0][7:0]});
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         tick();
      end
      start_done = words_done;
      drain(60);
      check("bp_words_out", words_done - start_done, 32'd5);

      // Stall in the high byte.
      out_ready = 1'b0;
      res_valid = 1'b1;
      res_data  = 16'hC3D4;
      tick();
      res_valid = 1'b0;
      tick();
      check("stall_lo", {24'd0, out_byte}, 32'hD4);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      start_done = words_done;
      for (int i = 0; i < 3; i++) begin
         check("stall_hi_byte", {24'd0, out_byte}, 32'hC3);
         check("stall_hi_last", {31'd0, out_last}, 32'd1);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("stall_done", {31'd0, out_valid}, 32'd0);
      check("stall_once", words_done - start_done, 32'd1);

      // Random stream through the wrapping FIFO.
      start_done = words_done;
      sent = 0;
      cyc  = 0;
      cur  = 16'($urandom);
      while (sent < 20 && cyc < 2000) begin
         out_ready = 1'($urandom % 2);
         if (!res_valid) res_valid = ($urandom % 3 != 0);
         res_data = cur;
         accepted = res_valid && res_ready;
         tick();
         cyc++;
         if (accepted) begin
            sent++;
            cur = 16'($urandom);
            res_valid = 1'b0;
         end
      end
      res_valid = 1'b0;
      check("rand_sent", sent, 32'd20);
      drain(200);
      check("rand_words_out", words_done - start_done, 32'd20);

      // Async reset while in the high byte with two words queued.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         res_valid = 1'b1;
         res_data  = 16'hA000 + 16'(i);
         tick();
      end
      res_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("ar_pre_last", {31'd0, out_last}, 32'd1);
      check("ar_pre_count", {29'd0, fifo_count}, 32'd2);
      #2;
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      check("ar_out_valid", {31'd0, out_valid}, 32'd0);
      check("ar_out_byte", {24'd0, out_byte}, 32'd0);
      check("ar_out_last", {31'd0, out_last}, 32'd0);
      check("ar_bus_oe", {24'd0, bus_oe}, 32'd0);
      check("ar_fifo_count", {29'd0, fifo_count}, 32'd0);
      check("ar_res_ready", {31'd0, res_ready}, 32'd1);
      tick();
      rst = 1'b0;
      model_q.delete();
      byte_idx = 1'b0;
      mon_en = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("ar_no_stale", {31'd0, out_valid}, 32'd0);
      end
      res_valid = 1'b1;
      res_data  = 16'h7E81;
      tick();
      res_valid = 1'b0;
      tick();
      check("ar_new_lo", {24'd0, out_byte}, 32'h81);
      tick();
      check("ar_new_hi", {24'd0, out_byte}, 32'h7E);
      tick();
      check("ar_new_end", {31'd0, out_valid}, 32'd0);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
